// File: rtl/rally_controller.sv
// rally_controller: per-frame Pong sequencer that owns the serve, miss detection, scoring, round pause and match end.
// Optional AUTO_RESTART_EN: MATCH_END also exits by itself after 4*RESTART_PAUSE frames.
module rally_controller #(
    parameter int VRES          = 720,
    parameter int PADDLE_H      = 20,
    parameter int RESTART_PAUSE = 128,
    parameter int WIN_SCORE     = 7,
    parameter int SCORE_W       = 4
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic               fsync,
    input  logic signed [11:0] vpos,
    input  logic               active_obj,
    input  logic               active_paddle_p1,
    input  logic               active_paddle_p2,
    input  logic               start,
    output logic               obj_rst,
    output logic               paddle_rst,
    output logic [1:0]         score_inc,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               round_over,
    output logic               match_over,
    output logic               winner
);
`ifdef AUTO_RESTART_EN
    localparam int END_FRAMES = 4 * RESTART_PAUSE;
    localparam int CW = $clog2(END_FRAMES + 1);
    localparam logic [CW-1:0] END_LAST = CW'(END_FRAMES - 1);
`else
    localparam int CW = $clog2(RESTART_PAUSE + 1);
`endif
    localparam logic signed [11:0] ROW_B = 12'(VRES - PADDLE_H);
    localparam logic signed [11:0] ROW_T = 12'(PADDLE_H);
    localparam logic [SCORE_W-1:0] SMAX = '1;
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
    localparam logic [CW-1:0] PAUSE_LAST = CW'(RESTART_PAUSE - 1);

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, PAUSE, MATCH_END} state_t;
    state_t state, state_nx;

    logic seen_b, hit_b, seen_t, hit_t;
    logic [CW-1:0] cnt;
    logic on_b, on_t, eval_b, eval_t, miss_p1, miss_p2, restart;
    logic [SCORE_W-1:0] p1_nx, p2_nx;

    assign obj_rst    = state != PLAY;
    assign paddle_rst = state != PLAY;
    assign round_over = state == PAUSE || state == MATCH_END;
    assign match_over = state == MATCH_END;

    // A row is judged on the first line after the ball was seen on it.
    always_comb begin
        on_b    = vpos == ROW_B;
        on_t    = vpos == ROW_T;
        eval_b  = state == PLAY && seen_b && !on_b;
        eval_t  = state == PLAY && seen_t && !on_t;
        miss_p1 = eval_b && !hit_b;
        miss_p2 = eval_t && !hit_t && !miss_p1;
        p1_nx   = score_p1 == SMAX ? SMAX : score_p1 + 1'b1;
        p2_nx   = score_p2 == SMAX ? SMAX : score_p2 + 1'b1;
`ifdef AUTO_RESTART_EN
        restart = start || (fsync && cnt == END_LAST);
`else
        restart = start;
`endif
        state_nx = state;
        case (state)
            IDLE:      state_nx = start ? SERVE : IDLE;
            SERVE:     state_nx = fsync ? PLAY : SERVE;
            PLAY:      state_nx = miss_p1 ? (p2_nx == WIN ? MATCH_END : PAUSE) :
                                  miss_p2 ? (p1_nx == WIN ? MATCH_END : PAUSE) : PLAY;
            PAUSE:     state_nx = (fsync && cnt == PAUSE_LAST) ? SERVE : PAUSE;
            MATCH_END: state_nx = restart ? SERVE : MATCH_END;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            score_inc <= '0;
            score_p1  <= '0;
            score_p2  <= '0;
            winner    <= 1'b0;
            cnt       <= '0;
            seen_b    <= 1'b0;
            hit_b     <= 1'b0;
            seen_t    <= 1'b0;
            hit_t     <= 1'b0;
        end else begin
            state     <= state_nx;
            score_inc <= {miss_p1, miss_p2};
            if (miss_p1) score_p2 <= p2_nx;
            if (miss_p2) score_p1 <= p1_nx;
            if (state == MATCH_END && restart) begin
                score_p1 <= '0;
                score_p2 <= '0;
            end
            if (state == PLAY && state_nx == MATCH_END) winner <= miss_p1;
            cnt <= state_nx != state ? '0 :
                   (fsync && round_over) ? cnt + 1'b1 : cnt;
            if (state != PLAY || fsync || eval_b) begin
                seen_b <= 1'b0;
                hit_b  <= 1'b0;
            end else if (on_b) begin
                seen_b <= seen_b | active_obj;
                hit_b  <= hit_b | (active_obj & active_paddle_p1);
            end
            if (state != PLAY || fsync || eval_t) begin
                seen_t <= 1'b0;
                hit_t  <= 1'b0;
            end else if (on_t) begin
                seen_t <= seen_t | active_obj;
                hit_t  <= hit_t | (active_obj & active_paddle_p2);
            end
        end
    end
endmodule
